// File: rtl/flash_arbiter_if.sv
// Requester-side bundle for one flash_arbiter port.
// The requester drives master; the arbiter takes slave.
interface flash_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              req;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, write, addr, wdata,
        input  done, err, rdata
    );

    modport slave (
        input  req, write, addr, wdata,
        output done, err, rdata
    );
endinterface

// File: rtl/flash_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the SPI flash
// controller, one transaction per grant, with a hung-transaction timeout.
module flash_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1048576,
    parameter int CNT_W   = 21
) (
    input  logic              clk,
    input  logic              reset,
    flash_arbiter_if.slave    p0,
    flash_arbiter_if.slave    p1,
    output logic              flash_en,
    output logic              flash_write,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [DATA_W-1:0] flash_data_in,
    input  logic [DATA_W-1:0] flash_data_out,
    input  logic              flash_ready,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              en_q, en_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdat0_q, rdat0_d;
    logic [DATA_W-1:0] rdat1_q, rdat1_d;
    logic              gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdat0_q <= '0;
            rdat1_q <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdat0_q <= rdat0_d;
            rdat1_q <= rdat1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        done_d  = 2'b00;
        err_d   = err_q;
        rdat0_d = rdat0_q;
        rdat1_d = rdat1_q;
        // port 1 wins when it is alone or the pointer favours it
        gnt     = p1.req && (!p0.req || prio_q);

        unique case (state_q)
            IDLE: begin
                if (p0.req || p1.req) begin
                    state_d = BUSY;
                    en_d    = 1'b1;
                    owner_d = gnt;
                    prio_d  = ~gnt;
                    cnt_d   = '0;
                    wr_d    = gnt ? p1.write : p0.write;
                    addr_d  = gnt ? p1.addr  : p0.addr;
                    wdat_d  = gnt ? p1.wdata : p0.wdata;
                end
            end
            BUSY: begin
                if (flash_ready) begin
                    state_d         = DONE;
                    en_d            = 1'b0;
                    err_d           = 1'b0;
                    done_d[owner_q] = 1'b1;
                    if (!wr_q) begin
                        if (owner_q) rdat1_d = flash_data_out;
                        else         rdat0_d = flash_data_out;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d         = DONE;
                    en_d            = 1'b0;
                    err_d           = 1'b1;
                    done_d[owner_q] = 1'b1;
                    if (owner_q) rdat1_d = '0;
                    else         rdat0_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign flash_en      = en_q;
    assign flash_write   = wr_q;
    assign flash_addr    = addr_q;
    assign flash_data_in = wdat_q;
    assign busy          = (state_q != IDLE);
    assign owner         = owner_q;

    assign p0.done  = done_q[0];
    assign p1.done  = done_q[1];
    assign p0.err   = done_q[0] & err_q;
    assign p1.err   = done_q[1] & err_q;
    assign p0.rdata = rdat0_q;
    assign p1.rdata = rdat1_q;
endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a short timeout.
// The flash controller side is driven by hand from the stimulus.
module tb_flash_arbiter;
    localparam int AW = 24;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          flash_en;
    logic          flash_write;
    logic [AW-1:0] flash_addr;
    logic [DW-1:0] flash_data_in;
    logic [DW-1:0] flash_data_out;
    logic          flash_ready;
    logic          busy;
    logic          owner;

    int n_cmp = 0;
    int n_bad = 0;

    flash_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
    flash_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

    flash_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(8),
        .CNT_W  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .p0            (p0_if),
        .p1            (p1_if),
        .flash_en      (flash_en),
        .flash_write   (flash_write),
        .flash_addr    (flash_addr),
        .flash_data_in (flash_data_in),
        .flash_data_out(flash_data_out),
        .flash_ready   (flash_ready),
        .busy          (busy),
        .owner         (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until flash_en is seen; gap counts low-en samples.
    task automatic wait_en(output int gap);
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            if (flash_en) break;
            tick();
            gap++;
        end
        if (!flash_en) chk("wait_en_bound", 32'(flash_en), 32'd1);
    endtask

    // From BUSY cycle 1, assert ready in BUSY cycle lat, return dones.
    task automatic serve(input int lat, input logic [DW-1:0] d,
                         output logic [1:0] dn);
        for (int i = 1; i < lat; i++) tick();
        flash_ready    = 1'b1;
        flash_data_out = d;
        tick();
        dn          = {p1_if.done, p0_if.done};
        flash_ready = 1'b0;
    endtask

    initial begin
        int          gap;
        logic [1:0]  dn;
        logic [AW-1:0] exp_addr [4];
        exp_addr[0] = 24'h10;
        exp_addr[1] = 24'h20;
        exp_addr[2] = 24'h10;
        exp_addr[3] = 24'h20;

        reset          = 1'b1;
        flash_ready    = 1'b0;
        flash_data_out = '0;
        p0_if.req = 0; p0_if.write = 0; p0_if.addr = '0; p0_if.wdata = '0;
        p1_if.req = 0; p1_if.write = 0; p1_if.addr = '0; p1_if.wdata = '0;
        tick();
        tick();
        chk("rst_en",    32'(flash_en), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_addr",  32'(flash_addr), 32'd0);
        chk("rst_done",  32'({p1_if.done, p0_if.done}), 32'd0);
        chk("rst_rd0",   p0_if.rdata, 32'd0);
        reset = 1'b0;

        // single read on port 0
        p0_if.req  = 1'b1;
        p0_if.addr = 24'h000100;
        tick();
        chk("rd_en",    32'(flash_en), 32'd1);
        chk("rd_addr",  32'(flash_addr), 32'h100);
        chk("rd_wr",    32'(flash_write), 32'd0);
        chk("rd_busy",  32'(busy), 32'd1);
        serve(5, 32'hDEADBEEF, dn);
        chk("rd_done",  32'(dn), 32'b01);
        chk("rd_data",  p0_if.rdata, 32'hDEADBEEF);
        chk("rd_err",   32'(p0_if.err), 32'd0);
        chk("rd_p1rd",  p1_if.rdata, 32'd0);
        chk("rd_en_lo", 32'(flash_en), 32'd0);
        p0_if.req = 1'b0;
        tick();
        chk("rd_pulse", 32'(p0_if.done), 32'd0);
        chk("rd_hold",  p0_if.rdata, 32'hDEADBEEF);

        // write on port 1, payload held through BUSY
        p1_if.req   = 1'b1;
        p1_if.write = 1'b1;
        p1_if.addr  = 24'h000400;
        p1_if.wdata = 32'h12345678;
        wait_en(gap);
        chk("wr_wr",    32'(flash_write), 32'd1);
        chk("wr_addr",  32'(flash_addr), 32'h400);
        chk("wr_owner", 32'(owner), 32'd1);
        tick();
        tick();
        chk("wr_data",  flash_data_in, 32'h12345678);
        chk("wr_en",    32'(flash_en), 32'd1);
        serve(2, 32'hAAAA5555, dn);
        chk("wr_done",  32'(dn), 32'b10);
        chk("wr_err",   32'(p1_if.err), 32'd0);
        chk("wr_rd1",   p1_if.rdata, 32'd0);
        p1_if.req   = 1'b0;
        p1_if.write = 1'b0;
        tick();

        // contention: both held, strict alternation
        p0_if.addr = 24'h10;
        p1_if.addr = 24'h20;
        p0_if.req  = 1'b1;
        p1_if.req  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_en(gap);
            if (t > 0) chk($sformatf("ct_gap%0d", t), 32'(gap >= 2), 32'd1);
            chk($sformatf("ct_addr%0d", t), 32'(flash_addr), 32'(exp_addr[t]));
            serve(3, 32'(t) + 32'h100, dn);
            chk($sformatf("ct_done%0d", t), 32'(dn),
                (t % 2 == 0) ? 32'b01 : 32'b10);
        end
        chk("ct_rd0", p0_if.rdata, 32'h102);
        chk("ct_rd1", p1_if.rdata, 32'h103);
        p0_if.req = 1'b0;
        p1_if.req = 1'b0;
        tick();
        tick();

        // timeout on port 0
        p0_if.req  = 1'b1;
        p0_if.addr = 24'h40;
        wait_en(gap);
        for (int i = 1; i < 8; i++) tick();
        chk("to_early", 32'(p0_if.done), 32'd0);
        tick();
        chk("to_done",  32'(p0_if.done), 32'd1);
        chk("to_err",   32'(p0_if.err), 32'd1);
        chk("to_rd",    p0_if.rdata, 32'd0);
        chk("to_en",    32'(flash_en), 32'd0);
        p0_if.req      = 1'b0;
        flash_ready    = 1'b1;
        flash_data_out = 32'h55555555;
        tick();
        chk("to_late_done", 32'(p0_if.done), 32'd0);
        tick();
        chk("to_late_busy", 32'(busy), 32'd0);
        chk("to_late_rd",   p0_if.rdata, 32'd0);
        flash_ready = 1'b0;
        tick();

        // ready on the terminal-count cycle
        p1_if.req  = 1'b1;
        p1_if.addr = 24'h80;
        wait_en(gap);
        serve(8, 32'hCAFEF00D, dn);
        chk("tie_done", 32'(dn), 32'b10);
        chk("tie_err",  32'(p1_if.err), 32'd0);
        chk("tie_rd",   p1_if.rdata, 32'hCAFEF00D);
        p1_if.req = 1'b0;
        tick();
        tick();

        // reset in BUSY cycle 2, pointer back to port 0
        p0_if.req  = 1'b1;
        p0_if.addr = 24'h300;
        wait_en(gap);
        tick();
        reset = 1'b1;
        tick();
        chk("mr_en",   32'(flash_en), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'({p1_if.done, p0_if.done}), 32'd0);
        reset      = 1'b0;
        p1_if.req  = 1'b1;
        p1_if.addr = 24'h500;
        tick();
        chk("mr_owner", 32'(owner), 32'd0);
        chk("mr_addr",  32'(flash_addr), 32'h300);
        tick();
        chk("mr_nodone", 32'({p1_if.done, p0_if.done}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
